// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, arbiter state encoding and client ids
package mem_if_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    localparam logic CLI_I = 1'b0;
    localparam logic CLI_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one slow-memory port between I-cache and D-cache
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter bit FIXED_D_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic i_req, d_req, grant_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
    // On a tie D wins when fixed priority is set or when I was served last.
    assign grant_d = d_req & (~i_req | FIXED_D_PRIO | (last_q == CLI_I));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req | d_req) begin
                    busy_d = 1'b1;
                    if (grant_d) begin
                        mem_read_d  = d_read;
                        mem_write_d = d_write;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        state_d     = ST_GNT_D;
                    end else begin
                        mem_read_d  = i_read;
                        mem_write_d = i_write;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = i_wdata;
                        state_d     = ST_GNT_I;
                    end
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                // Returning to IDLE forces one idle cycle before any new grant.
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    busy_d      = 1'b0;
                    last_d      = (state_q == ST_GNT_D) ? CLI_D : CLI_I;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= CLI_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

    assign i_ready = (state_q == ST_GNT_I) & mem_ready;
    assign d_ready = (state_q == ST_GNT_D) & mem_ready;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_if_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_rdata;
    logic          i_ready, d_ready, mem_ready;
    logic          mem_read, mem_write, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic [DW-1:0] f_i_rdata, f_d_rdata, f_mem_wdata;
    logic          f_i_ready, f_d_ready, f_mem_read, f_mem_write, f_busy;
    logic [AW-1:0] f_mem_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          cli;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        logic          ird, iwr, drd, dwr;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] iw, dw, rdat;
        logic          ecli;
        logic [AW-1:0] efaddr;
    } vec_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_D_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_D_PRIO(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(f_i_rdata), .i_ready(f_i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(f_d_rdata), .d_ready(f_d_ready),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(f_busy)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] w);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = w;
        req_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic wait_busy(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy === 1'b1) break;
        end
        chk1(name, busy, 1'b1);
    endtask

    // Called at a negedge inside a grant; leaves the bench at posedge+1 of the following IDLE cycle.
    task automatic mem_respond(input int lat, input logic [DW-1:0] data, input logic cli);
        rsp_t r;
        r.cli = cli; r.data = data;
        repeat (lat) @(posedge clk);
        #1;
        rsp_q.push_back(r);
        mem_rdata = data;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
    endtask

    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy === 1'b1 && busy_prev !== 1'b1) begin
                if (req_q.size() == 0) begin
                    chk1("unexpected_grant", 1'b1, 1'b0);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    chk1("sb_mem_read", mem_read, e.rd);
                    chk1("sb_mem_write", mem_write, e.wr);
                    chka("sb_mem_addr", mem_addr, e.addr);
                    chkd("sb_mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (i_ready === 1'b1 || d_ready === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    chk1("unexpected_ready", 1'b1, 1'b0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk1("sb_d_ready", d_ready, e.cli);
                    chk1("sb_i_ready", i_ready, ~e.cli);
                    chkd("sb_rdata", (e.cli == CLI_D) ? d_rdata : i_rdata, e.data);
                end
            end
        end
        busy_prev <= busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 28'h0001000, 28'h0002000, 128'h0, 128'h1111, 128'hAAAA_0000, CLI_D, 28'h0002000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 28'h0001010, 28'h0002010, 128'h0, 128'h2222, 128'hAAAA_0001, CLI_I, 28'h0002010};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 28'h0001020, 28'h0002020, 128'h0, 128'h0, 128'hAAAA_0002, CLI_D, 28'h0002020};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 28'h0001030, 28'h0002030, 128'h3333, 128'h0, 128'hAAAA_0003, CLI_I, 28'h0001030};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 28'h0001040, 28'h0002040, 128'h0, 128'h0, 128'hAAAA_0004, CLI_D, 28'h0002040};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 28'h0001050, 28'h0002050, 128'h0, 128'h0, 128'hAAAA_0005, CLI_I, 28'h0002050};

        clear_req();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 128'h5;
        repeat (2) @(negedge clk);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chka("rst_mem_addr", mem_addr, '0);
        chkd("rst_mem_wdata", mem_wdata, '0);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        mem_ready = 1'b0;
        rst_n = 1'b1;

        // I-only read, latency and completion
        step();
        push_req(1'b1, 1'b0, 28'h0000010, '0);
        i_read = 1'b1; i_addr = 28'h0000010;
        @(negedge clk);
        chk1("t1_no_comb_path", mem_read, 1'b0);
        @(negedge clk);
        chk1("t1_latency_read", mem_read, 1'b1);
        chka("t1_latency_addr", mem_addr, 28'h0000010);
        mem_respond(5, 128'hDEAD_BEEF, CLI_I);
        i_read = 1'b0;
        @(negedge clk);
        chk1("t1_read_dropped", mem_read, 1'b0);
        chk1("t1_busy_dropped", busy, 1'b0);

        // Simultaneous D write and I read: D first, one idle cycle, then I
        step();
        push_req(1'b0, 1'b1, 28'h0000200, 128'hA5A5_0000_1234);
        push_req(1'b1, 1'b0, 28'h0000300, '0);
        d_write = 1'b1; d_addr = 28'h0000200; d_wdata = 128'hA5A5_0000_1234;
        i_read = 1'b1; i_addr = 28'h0000300;
        wait_busy("tie_grant_wait");
        chk1("tie_d_first_write", mem_write, 1'b1);
        mem_respond(2, 128'hC0DE_0001, CLI_D);
        d_write = 1'b0;
        @(negedge clk);
        chk1("tie_idle_gap", busy, 1'b0);
        @(negedge clk);
        chk1("tie_i_granted", mem_read, 1'b1);
        mem_respond(3, 128'hC0DE_0002, CLI_I);
        i_read = 1'b0;

        // Arbitration table, both round-robin and fixed-priority instances
        for (int v = 0; v < 6; v++) begin
            step();
            i_read = tbl[v].ird; i_write = tbl[v].iwr; i_addr = tbl[v].ia; i_wdata = tbl[v].iw;
            d_read = tbl[v].drd; d_write = tbl[v].dwr; d_addr = tbl[v].da; d_wdata = tbl[v].dw;
            if (tbl[v].ecli == CLI_D) push_req(tbl[v].drd, tbl[v].dwr, tbl[v].da, tbl[v].dw);
            else                      push_req(tbl[v].ird, tbl[v].iwr, tbl[v].ia, tbl[v].iw);
            wait_busy("vec_grant_wait");
            chka("vec_fixed_prio_addr", f_mem_addr, tbl[v].efaddr);
            mem_respond(1 + (v % 3), tbl[v].rdat, tbl[v].ecli);
            clear_req();
        end

        // Captured address holds while the client changes its inputs
        step();
        push_req(1'b1, 1'b0, 28'h0000ABC, '0);
        d_read = 1'b1; d_addr = 28'h0000ABC;
        wait_busy("hold_grant_wait");
        step();
        d_addr = 28'h0000FFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chka("hold_mem_addr", mem_addr, 28'h0000ABC);
        end
        mem_respond(1, 128'hBEEF_0ABC, CLI_D);
        d_read = 1'b0;
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        chk1("idle_ready_i", i_ready, 1'b0);
        chk1("idle_ready_d", d_ready, 1'b0);
        step();
        mem_ready = 1'b0;

        // Asynchronous reset two cycles into GNT_I
        step();
        push_req(1'b1, 1'b0, 28'h0000444, '0);
        i_read = 1'b1; i_addr = 28'h0000444;
        wait_busy("rst_grant_wait");
        step();
        step();
        mem_ready = 1'b1;
        #1;
        chk1("rst_pre_i_ready", i_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("async_rst_mem_read", mem_read, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_i_ready", i_ready, 1'b0);
        mem_ready = 1'b0;
        i_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        step();
        push_req(1'b1, 1'b0, 28'h0000555, '0);
        d_read = 1'b1; d_addr = 28'h0000555;
        wait_busy("post_rst_grant_wait");
        mem_respond(2, 128'hFACE_0555, CLI_D);
        d_read = 1'b0;

        // D write-back then allocate read on the cycle after d_ready
        step();
        push_req(1'b0, 1'b1, 28'h0000666, 128'h6666_7777);
        push_req(1'b1, 1'b0, 28'h0000777, '0);
        d_write = 1'b1; d_addr = 28'h0000666; d_wdata = 128'h6666_7777;
        wait_busy("b2b_grant_wait");
        mem_respond(2, 128'h0, CLI_D);
        d_write = 1'b0; d_read = 1'b1; d_addr = 28'h0000777; d_wdata = '0;
        @(negedge clk);
        chk1("b2b_idle_gap", busy, 1'b0);
        @(negedge clk);
        chk1("b2b_second_grant", busy, 1'b1);
        mem_respond(3, 128'h7777_8888_9999, CLI_D);
        d_read = 1'b0;
        step();
        @(negedge clk);
        chki("req_queue_drained", req_q.size(), 0);
        chki("rsp_queue_drained", rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow-memory port between the I-cache and D-cache masters inside CHIP.
- Acts as responder to two cache-side initiators and as initiator toward one slow memory.
- All three ports use the same request/ready protocol:
  - The initiator holds read/write, addr and wdata until ready pulses for one cycle.
  - rdata is valid in the ready cycle.
- Lets a single-memory CHIP variant reuse the existing caches unchanged.

Parameters:
ADDR_W, 28, line address width (byte address bits 31:4)
DATA_W, 128, line data width
FIXED_D_PRIO, 0, 1 = D-side always wins a tie; 0 = round-robin tie-break

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_read  input  1  I-cache read request
i_write  input  1  I-cache write request (normally tied 0)
i_addr  input  ADDR_W  I-cache line address
i_wdata  input  DATA_W  I-cache write line
i_rdata  output  DATA_W  read line returned to I-cache
i_ready  output  1  I-side completion pulse
d_read  input  1  D-cache read request
d_write  input  1  D-cache write request
d_addr  input  ADDR_W  D-cache line address
d_wdata  input  DATA_W  D-cache write line
d_rdata  output  DATA_W  read line returned to D-cache
d_ready  output  1  D-side completion pulse
mem_read  output  1  registered read request to memory
mem_write  output  1  registered write request to memory
mem_addr  output  ADDR_W  registered line address
mem_wdata  output  DATA_W  registered write line
mem_rdata  input  DATA_W  memory read line
mem_ready  input  1  memory completion pulse
busy  output  1  high while a transaction is outstanding

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE; mem_read, mem_write, busy = 0.
  - mem_addr, mem_wdata = 0.
  - last_served = I, so the first tie goes to D.
  - i_ready, d_ready = 0.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - A client requests when (read | write) is high.
  - Only one client requests: grant it.
  - Both request:
    - FIXED_D_PRIO = 1: grant D.
    - Otherwise: grant the client that is not last_served.
  - On grant, at the same edge:
    - Capture that client's read, write, addr and wdata into the mem_* registers.
    - Set busy = 1 and go to GNT_x.
  - Latency: request seen in cycle N gives mem_* asserted in cycle N+1.
- GNT_x:
  - mem_* outputs hold the captured values; client inputs are ignored.
  - x_ready = mem_ready (combinational); x_rdata = mem_rdata.
  - The non-granted ready is 0; its rdata is don't-care (drive mem_rdata to both).
  - On the edge ending the mem_ready cycle:
    - Clear mem_read, mem_write and busy.
    - Set last_served = x; go to IDLE.
- Mandatory idle cycle: after every completion the arbiter spends at least one cycle in IDLE before a new grant.
  - The client drops its request by then, so the arbiter never re-grants a completed request.
  - A new request from the same client in that IDLE cycle is a new transaction and is arbitrated normally.
- Read and write both high from one client: forward both bits unchanged. This is a protocol violation; the arbiter does not check for it.
- A client withdrawing its request while granted is illegal. The arbiter keeps the captured transaction and still routes mem_ready to that client.
- mem_ready while in IDLE is ignored; neither x_ready pulses.
- Reset asserted mid-transaction: everything returns to reset values immediately. The memory sees its request drop.
- No combinational path from client inputs to mem_* outputs. The only combinational path is mem_ready/mem_rdata to x_ready/x_rdata.

Decomposition:
- Shared package (mem_if_pkg): ADDR_W/DATA_W defaults, the state encoding (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2), and client-id constants CLI_I=1'b0, CLI_D=1'b1.
- No sub-module needed. An optional rr_tiebreak helper is too small to justify a separate module, so keep everything in one module.

Test Plan:
- I-only read at addr 28'h0000010: mem_read=1 and mem_addr=28'h0000010 one cycle later. Memory returns 128'hDEAD_BEEF after 5 cycles. i_ready pulses once with i_rdata = that value; mem_read is low the next cycle.
- D write and I read raised in the same cycle after reset:
  - D granted first, since last_served = I at reset.
  - mem_write=1 with d_wdata captured.
  - After d_ready, one idle cycle, then the I read is granted.
- Repeat the simultaneous request with FIXED_D_PRIO=0 after D was last served: I is granted. With FIXED_D_PRIO=1: D is granted every time.
- While in GNT_D, change d_addr to 28'h0000FFF: mem_addr keeps the captured value. mem_ready in IDLE produces no client ready.
- Assert rst_n=0 two cycles into GNT_I: mem_read, busy and i_ready go to 0 without waiting for clk. After release, a fresh D request is granted normally.
- Back-to-back D write-back then allocate read (d_read raised in the cycle after d_ready): exactly one idle cycle between the two mem_* transactions; both complete with correct data.
